cp0_exc_ctrl: RTL and testbench

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

---
 rtl/cp0_pkg.sv | 42 ++++
 rtl/cp0_nest_stack.sv | 50 +++++
 rtl/cp0_exc_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 exception controller.
//   - CP0 register indices (Status / Cause / EPC)
//   - ExcCode values for every event the controller can take
//   - FSM state encoding
//   - stack entry width {IE, KSU[1:0], EPC[31:0]}
//   - fixed-priority exception code selection helper
package cp0_pkg;

    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_DZ  = 5'd7;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int STACK_W = 35;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_RETURN = 2'd2
    } cp0_state_e;

    // Highest-priority synchronous cause wins; falls back to the interrupt code.
    function automatic logic [4:0] sync_exc_code(input logic ri, input logic ov,
                                                 input logic dz, input logic sys,
                                                 input logic brk);
        logic [4:0] code;
        if (ri)       code = EXC_RI;
        else if (ov)  code = EXC_OV;
        else if (dz)  code = EXC_DZ;
        else if (sys) code = EXC_SYS;
        else if (brk) code = EXC_BP;
        else          code = EXC_INT;
        return code;
    endfunction

endpackage

// File: rtl/cp0_nest_stack.sv
// Save stack for nested exceptions.
// Ports:
//   clock, reset     clock / async active-low reset
//   push, pop        push push_data / drop top entry (push ignored when full,
//                    pop ignored when empty)
//   push_data        entry to save
//   top_data         most recently pushed entry (0 when empty)
//   level            number of valid entries (0..DEPTH)
module cp0_nest_stack
    import cp0_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = STACK_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [2:0]       level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [2:0]       level_q;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;

    assign wr_idx   = AW'(level_q);
    assign top_idx  = AW'(level_q - 3'd1);
    assign top_data = (level_q == 3'd0) ? '0 : mem_q[top_idx];
    assign level    = level_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && (level_q < 3'(DEPTH))) begin
            mem_q[wr_idx] <= push_data;
            level_q       <= level_q + 3'd1;
        end else if (pop && (level_q != 3'd0)) begin
            level_q <= level_q - 3'd1;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: Status/Cause/EPC registers, interrupt
// synchroniser, fixed-priority exception entry, eret return and a nesting
// stack of saved {IE, KSU, EPC}.
// Ports:
//   clock, reset                    clock / async active-low reset
//   overflow .. break_ins           synchronous exception sources
//   eret                            exception return
//   mtc0, mfc0, rd, rt_value        CP0 register write / read access
//   pc                              PC of the current instruction (saved to EPC)
//   irq                             asynchronous level interrupt requests
//   cp0_data_out                    mfc0 read data (combinational)
//   redirect, redirect_pc           one-cycle PC redirect strobe and target
//   nest_level, nest_fault          nesting depth / sticky nesting error
//
// state     | meaning
// ST_IDLE   | accepting events, eret and mtc0
// ST_ENTRY  | redirect to handler; pipeline flush, inputs ignored
// ST_RETURN | redirect to saved EPC; pipeline flush, inputs ignored
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ      = 6,
    parameter int          NEST_DEPTH   = 2,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000F000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               overflow,
    input  logic               divide_zero,
    input  logic               reserved_instruction,
    input  logic               syscall,
    input  logic               break_ins,
    input  logic               eret,
    input  logic               mtc0,
    input  logic               mfc0,
    input  logic [4:0]         rd,
    input  logic [31:0]        rt_value,
    input  logic [31:0]        pc,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [31:0]        cp0_data_out,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic [2:0]         nest_level,
    output logic               nest_fault
);

    logic [NUM_IRQ-1:0] irq_s1_q, irq_s2_q;
    logic               ie_q;
    logic [1:0]         ksu_q;
    logic [NUM_IRQ-1:0] im_q;
    logic [4:0]         exc_code_q;
    logic [31:0]        epc_q;
    cp0_state_e         state_q;
    logic               redirect_q;
    logic [31:0]        redirect_pc_q;
    logic               nest_fault_q;

    logic               sync_exc, int_req, stack_full, in_idle;
    logic               take_entry, take_return, exc_fault, ret_fault, do_write;
    logic [4:0]         entry_code;
    logic [STACK_W-1:0] stack_top;
    logic [2:0]         level;
    logic [5:0]         im_ext, ip_ext;

    cp0_nest_stack #(
        .DEPTH (NEST_DEPTH),
        .WIDTH (STACK_W)
    ) u_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (take_entry),
        .pop       (take_return),
        .push_data ({ie_q, ksu_q, epc_q}),
        .top_data  (stack_top),
        .level     (level)
    );

    always_comb begin
        sync_exc   = reserved_instruction | overflow | divide_zero | syscall | break_ins;
        int_req    = ie_q & (|(irq_s2_q & im_q));
        stack_full = (level == 3'(NEST_DEPTH));
        in_idle    = (state_q == ST_IDLE);
        entry_code = sync_exc_code(reserved_instruction, overflow, divide_zero,
                                   syscall, break_ins);
        // A present synchronous exception always shadows interrupts and eret,
        // even when it cannot be taken because the stack is full.
        take_entry  = in_idle & ~stack_full & (sync_exc | int_req);
        exc_fault   = in_idle & stack_full & sync_exc;
        take_return = in_idle & eret & ~sync_exc & ~take_entry & (level != 3'd0);
        ret_fault   = in_idle & eret & ~sync_exc & ~take_entry & (level == 3'd0);
        do_write    = in_idle & mtc0 & ~take_entry & ~take_return;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_s1_q      <= '0;
            irq_s2_q      <= '0;
            ie_q          <= 1'b0;
            ksu_q         <= 2'b00;
            im_q          <= '0;
            exc_code_q    <= 5'd0;
            epc_q         <= 32'd0;
            state_q       <= ST_IDLE;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            nest_fault_q  <= 1'b0;
        end else begin
            irq_s1_q <= irq;
            irq_s2_q <= irq_s1_q;

            case (state_q)
                ST_IDLE: begin
                    if (take_entry) begin
                        state_q       <= ST_ENTRY;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= HANDLER_ADDR;
                    end else if (take_return) begin
                        state_q       <= ST_RETURN;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= epc_q;
                    end else begin
                        redirect_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    redirect_q <= 1'b0;
                end
            endcase

            if (take_entry) begin
                epc_q      <= pc;
                ie_q       <= 1'b0;
                ksu_q      <= 2'b00;
                exc_code_q <= entry_code;
            end else if (take_return) begin
                {ie_q, ksu_q, epc_q} <= stack_top;
            end else if (do_write) begin
                case (rd)
                    CP0_REG_STATUS: begin
                        ie_q  <= rt_value[0];
                        ksu_q <= rt_value[4:3];
                        im_q  <= rt_value[10 +: NUM_IRQ];
                    end
                    CP0_REG_EPC: epc_q <= rt_value;
                    default: ;
                endcase
            end

            if (exc_fault || ret_fault) begin
                nest_fault_q <= 1'b1;
            end
        end
    end

    assign im_ext = 6'(im_q);
    assign ip_ext = 6'(irq_s2_q);

    always_comb begin
        cp0_data_out = 32'd0;
        if (mfc0) begin
            case (rd)
                CP0_REG_STATUS: begin
                    cp0_data_out[0]     = ie_q;
                    cp0_data_out[4:3]   = ksu_q;
                    cp0_data_out[15:10] = im_ext;
                end
                CP0_REG_CAUSE: begin
                    cp0_data_out[6:2]   = exc_code_q;
                    cp0_data_out[15:10] = ip_ext;
                end
                CP0_REG_EPC: cp0_data_out = epc_q;
                default: cp0_data_out = 32'd0;
            endcase
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign nest_level  = level;
    assign nest_fault  = nest_fault_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

    localparam logic [4:0] X_RI  = 5'b10000;
    localparam logic [4:0] X_OV  = 5'b01000;
    localparam logic [4:0] X_DZ  = 5'b00100;
    localparam logic [4:0] X_SYS = 5'b00010;
    localparam logic [4:0] X_BRK = 5'b00001;
    localparam logic [31:0] HADDR = 32'h0000F000;

    typedef struct packed {
        logic [4:0]  exc;
        logic        eret;
        logic        mtc0;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [5:0]  irq;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic [2:0]  e_lvl;
        logic        e_fault;
        logic        do_rd;
        logic [4:0]  rd_addr;
        logic [31:0] rd_exp;
    } vec_t;

    typedef struct packed {
        logic        redir;
        logic [31:0] rpc;
        logic [2:0]  lvl;
        logic        fault;
    } exp_t;

    logic        clock, reset;
    logic        overflow, divide_zero, reserved_instruction, syscall, break_ins;
    logic        eret, mtc0, mfc0;
    logic [4:0]  rd;
    logic [31:0] rt_value, pc;
    logic [5:0]  irq;
    logic [31:0] dout0, dout1, rpc0, rpc1;
    logic        redir0, redir1, fault0, fault1;
    logic [2:0]  lvl0, lvl1;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    vec_t tbl[$];

    cp0_exc_ctrl dut (
        .clock(clock), .reset(reset), .overflow(overflow), .divide_zero(divide_zero),
        .reserved_instruction(reserved_instruction), .syscall(syscall),
        .break_ins(break_ins), .eret(eret), .mtc0(mtc0), .mfc0(mfc0), .rd(rd),
        .rt_value(rt_value), .pc(pc), .irq(irq), .cp0_data_out(dout0),
        .redirect(redir0), .redirect_pc(rpc0), .nest_level(lvl0), .nest_fault(fault0)
    );

    cp0_exc_ctrl #(.NEST_DEPTH(1)) dut1 (
        .clock(clock), .reset(reset), .overflow(overflow), .divide_zero(divide_zero),
        .reserved_instruction(reserved_instruction), .syscall(syscall),
        .break_ins(break_ins), .eret(eret), .mtc0(mtc0), .mfc0(mfc0), .rd(rd),
        .rt_value(rt_value), .pc(pc), .irq(irq), .cp0_data_out(dout1),
        .redirect(redir1), .redirect_pc(rpc1), .nest_level(lvl1), .nest_fault(fault1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [4:0] exc, input logic er, input logic wr,
                                input logic [4:0] a, input logic [31:0] wd,
                                input logic [31:0] p, input logic [5:0] iq,
                                input logic e_r, input logic [31:0] e_pc,
                                input logic [2:0] e_l, input logic e_f,
                                input logic dr, input logic [4:0] ra,
                                input logic [31:0] re);
        vec_t v;
        v.exc = exc; v.eret = er; v.mtc0 = wr; v.rd = a; v.wdata = wd; v.pc = p;
        v.irq = iq; v.e_redir = e_r; v.e_rpc = e_pc; v.e_lvl = e_l; v.e_fault = e_f;
        v.do_rd = dr; v.rd_addr = ra; v.rd_exp = re;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        {reserved_instruction, overflow, divide_zero, syscall, break_ins} = v.exc;
        eret     = v.eret;
        mtc0     = v.mtc0;
        rd       = v.rd;
        rt_value = v.wdata;
        pc       = v.pc;
        irq      = v.irq;
    endtask

    task automatic rd_chk(input string name, input int which, input logic [4:0] a,
                          input logic [31:0] exp);
        logic [4:0] rd_save;
        rd_save = rd;
        rd   = a;
        mfc0 = 1'b1;
        #1;
        chk(name, (which == 0) ? dout0 : dout1, exp);
        mfc0 = 1'b0;
        rd   = rd_save;
    endtask

    task automatic step(input string tag, input vec_t v);
        exp_t e;
        drive(v);
        sb.push_back({v.e_redir, v.e_rpc, v.e_lvl, v.e_fault});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({tag, " redirect"},    32'(redir0),  32'(e.redir));
        chk({tag, " redirect_pc"}, rpc0,         e.rpc);
        chk({tag, " nest_level"},  32'(lvl0),    32'(e.lvl));
        chk({tag, " nest_fault"},  32'(fault0),  32'(e.fault));
        if (v.do_rd) rd_chk({tag, " mfc0"}, 0, v.rd_addr, v.rd_exp);
    endtask

    task automatic reset_dut();
        drive('0);
        mfc0  = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        vec_t idle;
        idle = '0;
        mfc0 = 1'b0;
        reset_dut();

        chk("reset redirect",    32'(redir0), 32'd0);
        chk("reset redirect_pc", rpc0, 32'd0);
        chk("reset nest_level",  32'(lvl0), 32'd0);
        chk("reset nest_fault",  32'(fault0), 32'd0);
        rd_chk("reset status", 0, 5'd12, 32'd0);
        rd_chk("reset cause",  0, 5'd13, 32'd0);
        rd_chk("reset epc",    0, 5'd14, 32'd0);

        //                exc          er wr rd     wdata         pc            irq    rdr rpc           l  f  chk ra     rd_exp
        tbl.push_back(mk(5'b0,         0, 1, 5'd12, 32'h0000_0401, 32'h0,        6'h0, 0, 32'h0,        0, 0, 1, 5'd12, 32'h401));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h1, 0, 32'h0,        0, 0, 0, 5'd0,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h1, 0, 32'h0,        0, 0, 0, 5'd0,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h300,      6'h1, 1, HADDR,        1, 0, 1, 5'd14, 32'h300));
        tbl.push_back(mk(5'b0,         0, 1, 5'd14, 32'hDEAD,      32'h304,      6'h1, 0, HADDR,        1, 0, 1, 5'd13, 32'h400));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, HADDR,        1, 0, 1, 5'd12, 32'h400));
        tbl.push_back(mk(5'b0,         1, 0, 5'd0,  32'h0,         32'h0,        6'h0, 1, 32'h300,      0, 0, 1, 5'd14, 32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, 32'h300,      0, 0, 1, 5'd12, 32'h401));
        tbl.push_back(mk(X_SYS,        0, 0, 5'd0,  32'h0,         32'h100,      6'h0, 1, HADDR,        1, 0, 0, 5'd0,  32'h0));
        tbl.push_back(mk(X_BRK,        0, 0, 5'd0,  32'h0,         32'h999,      6'h0, 0, HADDR,        1, 0, 1, 5'd13, 32'h20));
        tbl.push_back(mk(5'b0,         1, 0, 5'd0,  32'h0,         32'h0,        6'h0, 1, 32'h100,      0, 0, 0, 5'd0,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, 32'h100,      0, 0, 1, 5'd14, 32'h0));
        tbl.push_back(mk(X_OV,         0, 0, 5'd0,  32'h0,         32'h200,      6'h0, 1, HADDR,        1, 0, 0, 5'd0,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, HADDR,        1, 0, 1, 5'd13, 32'h30));
        tbl.push_back(mk(X_BRK,        0, 0, 5'd0,  32'h0,         32'hF004,     6'h0, 1, HADDR,        2, 0, 0, 5'd0,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, HADDR,        2, 0, 1, 5'd14, 32'hF004));
        tbl.push_back(mk(X_DZ,         0, 0, 5'd0,  32'h0,         32'hF008,     6'h0, 0, HADDR,        2, 1, 1, 5'd14, 32'hF004));
        tbl.push_back(mk(5'b0,         1, 0, 5'd0,  32'h0,         32'h0,        6'h0, 1, 32'hF004,     1, 1, 0, 5'd0,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, 32'hF004,     1, 1, 1, 5'd14, 32'h200));
        tbl.push_back(mk(5'b0,         1, 0, 5'd0,  32'h0,         32'h0,        6'h0, 1, 32'h200,      0, 1, 0, 5'd0,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, 32'h200,      0, 1, 1, 5'd14, 32'h0));
        tbl.push_back(mk(5'b11111,     1, 0, 5'd0,  32'h0,         32'h500,      6'h0, 1, HADDR,        1, 1, 0, 5'd0,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, HADDR,        1, 1, 1, 5'd13, 32'h28));
        tbl.push_back(mk(X_OV|X_DZ|X_SYS, 0, 0, 5'd0, 32'h0,       32'h504,      6'h0, 1, HADDR,        2, 1, 0, 5'd0,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, HADDR,        2, 1, 1, 5'd13, 32'h30));
        tbl.push_back(mk(5'b0,         1, 0, 5'd0,  32'h0,         32'h0,        6'h0, 1, 32'h504,      1, 1, 0, 5'd0,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, 32'h504,      1, 1, 1, 5'd13, 32'h30));
        tbl.push_back(mk(X_DZ,         0, 1, 5'd14, 32'hABCD,      32'h600,      6'h0, 1, HADDR,        2, 1, 0, 5'd0,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, HADDR,        2, 1, 1, 5'd14, 32'h600));
        tbl.push_back(mk(5'b0,         0, 1, 5'd5,  32'hFFFF_FFFF, 32'h0,        6'h0, 0, HADDR,        2, 1, 1, 5'd5,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, HADDR,        2, 1, 1, 5'd13, 32'h1C));
        tbl.push_back(mk(5'b0,         0, 1, 5'd14, 32'h1234,      32'h0,        6'h0, 0, HADDR,        2, 1, 1, 5'd14, 32'h1234));
        tbl.push_back(mk(5'b0,         1, 0, 5'd0,  32'h0,         32'h0,        6'h0, 1, 32'h1234,     1, 1, 0, 5'd0,  32'h0));
        tbl.push_back(mk(5'b0,         0, 0, 5'd0,  32'h0,         32'h0,        6'h0, 0, 32'h1234,     1, 1, 1, 5'd14, 32'h500));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("row%0d", i), tbl[i]);
        end

        // eret at level 0, then overflow+eret together
        reset_dut();
        step("eret_l0", mk(5'b0, 1, 0, 5'd0, 32'h0, 32'h0, 6'h0, 0, 32'h0, 0, 1, 0, 5'd0, 32'h0));
        step("ov_eret", mk(X_OV, 1, 0, 5'd0, 32'h0, 32'h40, 6'h0, 1, HADDR, 1, 1, 1, 5'd13, 32'h30));

        // interrupt masked by IM, then unmasked
        reset_dut();
        step("im_wr",  mk(5'b0, 0, 1, 5'd12, 32'h0000_0801, 32'h0, 6'h1, 0, 32'h0, 0, 0, 0, 5'd0, 32'h0));
        step("im_s1",  mk(5'b0, 0, 0, 5'd0, 32'h0, 32'h0, 6'h1, 0, 32'h0, 0, 0, 0, 5'd0, 32'h0));
        step("im_blk", mk(5'b0, 0, 0, 5'd0, 32'h0, 32'h70, 6'h1, 0, 32'h0, 0, 0, 1, 5'd13, 32'h400));
        step("im_blk2",mk(5'b0, 0, 0, 5'd0, 32'h0, 32'h74, 6'h1, 0, 32'h0, 0, 0, 0, 5'd0, 32'h0));
        step("im_irq1",mk(5'b0, 0, 0, 5'd0, 32'h0, 32'h78, 6'h3, 0, 32'h0, 0, 0, 0, 5'd0, 32'h0));
        step("im_irq2",mk(5'b0, 0, 0, 5'd0, 32'h0, 32'h7C, 6'h3, 0, 32'h0, 0, 0, 0, 5'd0, 32'h0));
        step("im_take",mk(5'b0, 0, 0, 5'd0, 32'h0, 32'h80, 6'h3, 1, HADDR, 1, 0, 1, 5'd14, 32'h80));

        // reset pulsed during ENTRY
        reset_dut();
        step("sys_entry", mk(X_SYS, 0, 0, 5'd0, 32'h0, 32'h100, 6'h0, 1, HADDR, 1, 0, 1, 5'd13, 32'h20));
        reset = 1'b0;
        #1;
        chk("rst_mid redirect",    32'(redir0), 32'd0);
        chk("rst_mid redirect_pc", rpc0, 32'd0);
        chk("rst_mid nest_level",  32'(lvl0), 32'd0);
        rd_chk("rst_mid status", 0, 5'd12, 32'd0);
        rd_chk("rst_mid cause",  0, 5'd13, 32'd0);
        rd_chk("rst_mid epc",    0, 5'd14, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // single-level configuration: second exception faults
        reset_dut();
        drive(mk(X_SYS, 0, 0, 5'd0, 32'h0, 32'h10, 6'h0, 0, 32'h0, 0, 0, 0, 5'd0, 32'h0));
        @(posedge clock); #1;
        chk("d1 entry redirect", 32'(redir1), 32'd1);
        chk("d1 entry level",    32'(lvl1), 32'd1);
        drive(idle);
        @(posedge clock); #1;
        drive(mk(X_OV, 0, 0, 5'd0, 32'h0, 32'h20, 6'h0, 0, 32'h0, 0, 0, 0, 5'd0, 32'h0));
        @(posedge clock); #1;
        chk("d1 full redirect", 32'(redir1), 32'd0);
        chk("d1 full fault",    32'(fault1), 32'd1);
        chk("d1 full level",    32'(lvl1), 32'd1);
        rd_chk("d1 full epc",   1, 5'd14, 32'h10);
        rd_chk("d1 full cause", 1, 5'd13, 32'h20);
        drive(idle);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
